// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one external memory port between instruction fetch (requester 0)
// and the L1 data cache refill/writeback path (requester 1). One line-sized
// burst is granted at a time, round-robin on ties.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   req_valid/ready/addr/we   per-requester address phase
//   req_wdata/wvalid/wready   per-requester write beats
//   rsp_rdata/rvalid/done     read beats (data broadcast) and completion pulse
//   mem_req_valid/ready, mem_addr, mem_we        memory address phase
//   mem_wdata/wvalid/wready, mem_rdata/rvalid    memory data beats
//   mem_wack                  memory write completion
//   busy, grant               activity flag, current/last granted requester
//
// state | meaning
// IDLE  | no transaction; arbitrate among req_valid
// ADDR  | address phase offered to memory for the granted requester
// WDATA | forwarding BEATS write beats
// WACK  | waiting for memory write completion
// RDATA | forwarding BEATS read beats
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int BEATS  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             req_valid,
   output logic [1:0]             req_ready,
   input  logic [1:0][ADDR_W-1:0] req_addr,
   input  logic [1:0]             req_we,
   input  logic [1:0][DATA_W-1:0] req_wdata,
   input  logic [1:0]             req_wvalid,
   output logic [1:0]             req_wready,
   output logic [DATA_W-1:0]      rsp_rdata,
   output logic [1:0]             rsp_rvalid,
   output logic [1:0]             rsp_done,
   output logic                   mem_req_valid,
   input  logic                   mem_req_ready,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic                   mem_we,
   output logic [DATA_W-1:0]      mem_wdata,
   output logic                   mem_wvalid,
   input  logic                   mem_wready,
   input  logic [DATA_W-1:0]      mem_rdata,
   input  logic                   mem_rvalid,
   input  logic                   mem_wack,
   output logic                   busy,
   output logic                   grant
);

   localparam int CNT_W = $clog2(BEATS + 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [2:0] {IDLE, ADDR, WDATA, WACK, RDATA} state_t;

   state_t           state_q, state_d;
   logic             grant_q, grant_d;
   logic             rr_q, rr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wdone_q, wdone_d;
   logic [1:0]       gsel;

   assign gsel  = grant_q ? 2'b10 : 2'b01;
   assign grant = grant_q;
   assign busy  = (state_q != IDLE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
         rr_q    <= 1'b1;
         cnt_q   <= '0;
         wdone_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         wdone_q <= wdone_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      rr_d          = rr_q;
      cnt_d         = cnt_q;
      wdone_d       = 1'b0;
      req_ready     = 2'b00;
      req_wready    = 2'b00;
      rsp_rdata     = '0;
      rsp_rvalid    = 2'b00;
      mem_req_valid = 1'b0;
      mem_addr      = '0;
      mem_we        = 1'b0;
      mem_wdata     = '0;
      mem_wvalid    = 1'b0;
      // Write completion is registered, so its pulse lands in the IDLE cycle
      // that follows mem_wack; grant_q still names the finished requester.
      rsp_done      = wdone_q ? gsel : 2'b00;

      case (state_q)
         IDLE: begin
            if (req_valid == 2'b11) begin
               grant_d = ~rr_q;
               state_d = ADDR;
            end else if (req_valid[0]) begin
               grant_d = 1'b0;
               state_d = ADDR;
            end else if (req_valid[1]) begin
               grant_d = 1'b1;
               state_d = ADDR;
            end
         end
         ADDR: begin
            mem_req_valid = req_valid[grant_q];
            mem_addr      = req_addr[grant_q];
            mem_we        = req_we[grant_q];
            req_ready     = gsel & {2{mem_req_ready}};
            if (!req_valid[grant_q]) begin
               // requester withdrew before acceptance; pointer untouched
               state_d = IDLE;
            end else if (mem_req_ready) begin
               cnt_d   = '0;
               state_d = req_we[grant_q] ? WDATA : RDATA;
            end
         end
         WDATA: begin
            mem_wdata  = req_wdata[grant_q];
            mem_wvalid = req_wvalid[grant_q];
            req_wready = gsel & {2{mem_wready}};
            if (req_wvalid[grant_q] && mem_wready) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_BEAT) state_d = WACK;
            end
         end
         WACK: begin
            if (mem_wack) begin
               wdone_d = 1'b1;
               rr_d    = grant_q;
               state_d = IDLE;
            end
         end
         RDATA: begin
            rsp_rdata  = mem_rdata;
            rsp_rvalid = gsel & {2{mem_rvalid}};
            if (mem_rvalid) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_BEAT) begin
                  rsp_done = gsel;
                  rr_d     = grant_q;
                  state_d  = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BEATS  = 4;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [1:0]             req_valid;
   logic [1:0]             req_ready;
   logic [1:0][ADDR_W-1:0] req_addr;
   logic [1:0]             req_we;
   logic [1:0][DATA_W-1:0] req_wdata;
   logic [1:0]             req_wvalid;
   logic [1:0]             req_wready;
   logic [DATA_W-1:0]      rsp_rdata;
   logic [1:0]             rsp_rvalid;
   logic [1:0]             rsp_done;
   logic                   mem_req_valid;
   logic                   mem_req_ready;
   logic [ADDR_W-1:0]      mem_addr;
   logic                   mem_we;
   logic [DATA_W-1:0]      mem_wdata;
   logic                   mem_wvalid;
   logic                   mem_wready;
   logic [DATA_W-1:0]      mem_rdata;
   logic                   mem_rvalid;
   logic                   mem_wack;
   logic                   busy;
   logic                   grant;

   int n_vec = 0;
   int n_err = 0;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_we(req_we), .req_wdata(req_wdata), .req_wvalid(req_wvalid),
      .req_wready(req_wready), .rsp_rdata(rsp_rdata), .rsp_rvalid(rsp_rvalid),
      .rsp_done(rsp_done), .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_wack(mem_wack),
      .busy(busy), .grant(grant)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic read_beats(input logic [1:0] who, input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = base + 32'(i);
         #1;
         chk("rd_valid", rsp_rvalid, who);
         chk("rd_data", rsp_rdata, base + 32'(i));
         chk("rd_done", rsp_done, (i == BEATS - 1) ? who : 2'b00);
         tick();
      end
      mem_rvalid = 1'b0;
   endtask

   logic [31:0] wexp [4];
   int          hs;
   logic        exp_g;
   int          ng;
   logic        prev_done;

   initial begin
      wexp[0] = 32'h11; wexp[1] = 32'h22; wexp[2] = 32'h33; wexp[3] = 32'h44;
      rst = 1'b0;
      req_valid = '0; req_addr = '0; req_we = '0; req_wdata = '0; req_wvalid = '0;
      mem_req_ready = 1'b0; mem_wready = 1'b0; mem_rdata = '0;
      mem_rvalid = 1'b0; mem_wack = 1'b0;
      tick(); tick();

      // reset state
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant, 0);
      chk("rst_mreq", mem_req_valid, 0);
      chk("rst_done", rsp_done, 0);
      chk("rst_ready", req_ready, 0);
      rst = 1'b1;
      tick();

      // requester 0 read of 0x100
      req_valid = 2'b01; req_we = 2'b00; req_addr[0] = 32'h100;
      #1;
      chk("t1_mreq_t0", mem_req_valid, 0);
      tick();
      mem_req_ready = 1'b1;
      #1;
      chk("t1_mreq_t1", mem_req_valid, 1);
      chk("t1_addr", mem_addr, 32'h100);
      chk("t1_we", mem_we, 0);
      chk("t1_ready", req_ready, 2'b01);
      chk("t1_grant", grant, 0);
      tick();
      mem_req_ready = 1'b0; req_valid = 2'b00;
      read_beats(2'b01, 32'hA0, BEATS);
      #1;
      chk("t1_busy_end", busy, 0);
      chk("t1_done_end", rsp_done, 0);

      // spurious memory responses while idle
      mem_rvalid = 1'b1; mem_wack = 1'b1;
      #1;
      chk("t6_rvalid", rsp_rvalid, 0);
      chk("t6_done", rsp_done, 0);
      tick();
      chk("t6_busy", busy, 0);
      chk("t6_done2", rsp_done, 0);
      mem_rvalid = 1'b0; mem_wack = 1'b0;

      // requester 1 write of 0x2000 with mem_wready toggling
      req_valid = 2'b10; req_we = 2'b10; req_addr[1] = 32'h2000;
      req_wvalid = 2'b10; req_wdata[1] = wexp[0];
      tick();
      mem_req_ready = 1'b1;
      #1;
      chk("t3_addr", mem_addr, 32'h2000);
      chk("t3_we", mem_we, 1);
      chk("t3_ready", req_ready, 2'b10);
      chk("t3_grant", grant, 1);
      tick();
      mem_req_ready = 1'b0; req_valid = 2'b00;
      hs = 0;
      for (int c = 0; c < 16 && hs < BEATS; c++) begin
         mem_wready = (c % 2 == 0);
         req_wdata[1] = wexp[hs];
         #1;
         chk("t3_wvalid", mem_wvalid, 1);
         chk("t3_wready", req_wready, {mem_wready, 1'b0});
         if (mem_wvalid && mem_wready) begin
            chk("t3_wdata", mem_wdata, wexp[hs]);
            hs++;
         end
         tick();
      end
      chk("t3_hs_count", hs, BEATS);
      mem_wready = 1'b1; req_wdata[1] = 32'h55;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("t3_wack_wvalid", mem_wvalid, 0);
         chk("t3_wack_wready", req_wready, 0);
         chk("t3_wack_busy", busy, 1);
         chk("t3_wack_done", rsp_done, 0);
         tick();
      end
      mem_wready = 1'b0; req_wvalid = 2'b00;
      mem_wack = 1'b1;
      #1;
      chk("t3_done_early", rsp_done, 0);
      tick();
      mem_wack = 1'b0;
      chk("t3_done", rsp_done, 2'b10);
      chk("t3_busy", busy, 0);
      tick();
      chk("t3_done_once", rsp_done, 0);

      // address phase stalled by memory
      req_valid = 2'b01; req_we = 2'b00; req_addr[0] = 32'h300;
      tick();
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("t4_mreq", mem_req_valid, 1);
         chk("t4_addr", mem_addr, 32'h300);
         chk("t4_ready", req_ready, 0);
         chk("t4_busy", busy, 1);
         tick();
      end
      mem_req_ready = 1'b1;
      #1;
      chk("t4_ready_hs", req_ready, 2'b01);
      tick();
      mem_req_ready = 1'b0; req_valid = 2'b00;
      read_beats(2'b01, 32'hB0, BEATS);

      // reset during RDATA after two beats
      req_valid = 2'b10; req_addr[1] = 32'h400;
      tick();
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0; req_valid = 2'b00;
      read_beats(2'b10, 32'hC0, 2);
      rst = 1'b0; mem_rvalid = 1'b1;
      tick();
      rst = 1'b1;
      #1;
      chk("t5_busy", busy, 0);
      chk("t5_rvalid", rsp_rvalid, 0);
      chk("t5_done", rsp_done, 0);
      chk("t5_grant", grant, 0);
      chk("t5_mreq", mem_req_valid, 0);
      tick();
      chk("t5_busy2", busy, 0);
      chk("t5_rvalid2", rsp_rvalid, 0);

      // both requesting continuously: first grant after reset is 0, then alternate
      req_valid = 2'b11; req_we = 2'b00; mem_req_ready = 1'b1; mem_rvalid = 1'b1;
      exp_g = 1'b0; ng = 0; prev_done = 1'b0;
      for (int c = 0; c < 80 && ng < 4; c++) begin
         #1;
         if (prev_done) chk("t2_idle_gap", busy, 0);
         if (mem_req_valid && mem_req_ready) begin
            chk("t2_grant", grant, exp_g);
            chk("t2_ready", req_ready, exp_g ? 2'b10 : 2'b01);
            exp_g = ~exp_g;
            ng++;
         end
         prev_done = |rsp_done;
         tick();
      end
      chk("t2_grant_count", ng, 4);
      req_valid = 2'b00;
      for (int c = 0; c < 6; c++) tick();
      mem_rvalid = 1'b0; mem_req_ready = 1'b0;
      #1;
      chk("t2_busy_end", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter that shares the single external memory port between instruction fetch (requester 0) and the L1 data cache refill/writeback path (requester 1, L1DCache).
- Sits between the core-side caches and the memory bus.
- Grants one line-sized burst transaction at a time under round-robin priority.
- Sequences the address phase, the write-data beats or read-data beats, and write completion.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, data beat width.
BEATS, 4, beats per line transaction (>=1); beat counter is $clog2(BEATS+1) bits wide.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-low (rst==0 resets on the rising edge of clk).
req_valid  in  2  per-requester transaction request.
req_ready  out  2  per-requester address-phase accept.
req_addr  in  2xADDR_W  per-requester line address.
req_we  in  2  per-requester write (1) or read (0).
req_wdata  in  2xDATA_W  per-requester write beat.
req_wvalid  in  2  per-requester write beat valid.
req_wready  out  2  per-requester write beat accept.
rsp_rdata  out  DATA_W  read beat, broadcast to both requesters.
rsp_rvalid  out  2  read beat valid, only the granted requester's bit.
rsp_done  out  2  one-cycle transaction-complete pulse.
mem_req_valid  out  1  memory address phase valid.
mem_req_ready  in  1  memory address phase accept.
mem_addr  out  ADDR_W  address to memory.
mem_we  out  1  write flag to memory.
mem_wdata  out  DATA_W  write beat to memory.
mem_wvalid  out  1  write beat valid.
mem_wready  in  1  memory write beat accept.
mem_rdata  in  DATA_W  read beat from memory.
mem_rvalid  in  1  read beat valid.
mem_wack  in  1  write completion from memory.
busy  out  1  high in any state other than IDLE.
grant  out  1  index of the current or last granted requester.

Behaviour:
- States: IDLE, ADDR, WDATA, WACK, RDATA.
- Reset (rst==0):
  - State goes to IDLE; all outputs are 0.
  - Beat counter is cleared; rr pointer (last granted) is set to 1, so requester 0 wins the first tie.
  - Reset mid-transaction abandons the transaction; memory beats or acks arriving afterwards are ignored while in IDLE.
- IDLE:
  - If neither req_valid bit is set, stay in IDLE.
  - If exactly one is set, grant that requester.
  - If both are set, grant the requester that is not the rr pointer.
  - grant is registered and the state goes to ADDR on the next edge.
  - Latency: req_valid seen at cycle t gives mem_req_valid at cycle t+1.
- ADDR:
  - mem_req_valid=req_valid[grant]; mem_addr and mem_we come from req_addr/req_we[grant].
  - req_ready[grant]=mem_req_ready; the other req_ready bit is 0.
  - On handshake, clear the beat counter, then go to WDATA if we=1, else RDATA.
  - If req_valid[grant] drops before the handshake: return to IDLE, no rsp_done, pointer unchanged.
- WDATA:
  - mem_wdata and mem_wvalid come from req_wdata/req_wvalid[grant]; req_wready[grant]=mem_wready.
  - Each handshake increments the counter; the BEATS-th handshake moves to WACK.
  - There is no timeout: stalls hold indefinitely.
- WACK:
  - Wait for mem_wack.
  - Then pulse rsp_done[grant] for 1 cycle, set pointer=grant, go to IDLE.
- RDATA:
  - rsp_rvalid[grant]=mem_rvalid; rsp_rdata=mem_rdata. Both are combinational pass-through, with no added latency.
  - On the BEATS-th beat, rsp_done[grant] is asserted in the same cycle as that last rsp_rvalid; then pointer=grant and go to IDLE.
- Boundary conditions:
  - A non-granted requester never sees req_ready, req_wready, rsp_rvalid or rsp_done.
  - mem_rvalid outside RDATA and mem_wack outside WACK are ignored.
  - mem_wvalid is 0 outside WDATA; mem_req_valid is 0 outside ADDR.
  - BEATS=1: a single beat completes the data phase.
  - There is at least one IDLE cycle between transactions; with both requesters continuously requesting, grants strictly alternate 0,1,0,1.
  - Requester inputs must be stable while valid and not yet accepted; the arbiter does not re-sample addr/we after the ADDR handshake.

Test Plan:
1. Reset, then req_valid=01, read, addr=0x100, memory returns beats 0xA0..0xA3 -> mem_req_valid at t+1 with addr 0x100, we=0; rsp_rvalid=01 for 4 beats with matching data; rsp_done=01 with the 4th beat; busy low afterwards.
2. req_valid=11 asserted together and held -> grant sequence 0,1,0,1 across four transactions; each grant separated by 1 IDLE cycle; the other requester's req_ready stays 0.
3. Requester 1 write, addr 0x2000, data 0x11..0x44, mem_wready toggling 1,0,1 -> exactly 4 mem_wvalid&mem_wready handshakes carrying 0x11..0x44 in order; WACK held until mem_wack; rsp_done=10 the cycle after mem_wack.
4. mem_req_ready held 0 for 5 cycles during ADDR -> mem_req_valid stays 1 with a stable address; req_ready=0; no state change until mem_req_ready=1.
5. rst driven low during RDATA after 2 beats -> next cycle busy=0, all outputs 0; further mem_rvalid is ignored; the next req_valid=11 grants requester 0.
6. Spurious mem_rvalid=1 and mem_wack=1 while IDLE -> rsp_rvalid=00, rsp_done=00, state remains IDLE.
